stride_read_master: RTL and testbench

AXI read-address/read-data initiator that issues a programmed sequence of strided read bursts and consumes their data beats. It drives the slave-side read channels of the prefetcher (or a RAM model directly) and is the requesting end of the same AR/R interface the prefetcher serves. It checks response ordering, ID and burst length, and folds received data into an XOR signature for self-checking benches and traffic generation.

---
 rtl/stride_read_pkg.sv | 19 +
 rtl/stride_read_rtrack.sv | 78 +++++++
 rtl/stride_read_master.sv | 203 ++++++++++++++++++++
 tb/tb_stride_read_master.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stride_read_pkg.sv
// Shared types and constants for the strided AXI read initiator.
package stride_read_pkg;

    // Sequencer states, exposed on the debug port of the top.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sticky error codes reported on errorCode; 0 means no error seen.
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_EARLY_LAST   = 3'd1;
    localparam logic [2:0] ERR_MISSING_LAST = 3'd2;
    localparam logic [2:0] ERR_BAD_ID       = 3'd3;
    localparam logic [2:0] ERR_UNSOLICITED  = 3'd4;

endpackage

// File: rtl/stride_read_rtrack.sv
// Read-side tracker: outstanding burst count, per-burst beat count and
// the checks applied to every R handshake. burst_done and err are
// combinational views of the current-cycle handshake for the top FSM.
module stride_read_rtrack
    import stride_read_pkg::*;
#(
    parameter int BURST_LEN_WIDTH     = 8,
    parameter int TID_WIDTH           = 8,
    parameter int LOG_MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       i_clear,
    input  logic                       i_ar_hs,
    input  logic                       i_r_hs,
    input  logic                       i_r_last,
    input  logic [TID_WIDTH-1:0]       i_r_id,
    input  logic [BURST_LEN_WIDTH-1:0] i_len,
    input  logic [TID_WIDTH-1:0]       i_id,
    output logic                       o_burst_done,
    output logic                       o_full_next,
    output logic [2:0]                 o_err
);

    localparam int OUT_W = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(1) << LOG_MAX_OUTSTANDING;

    logic [OUT_W-1:0]           r_outstanding;
    logic [BURST_LEN_WIDTH-1:0] r_beat;
    logic [OUT_W-1:0]           w_out_next;
    logic                       w_solicited;
    logic                       w_final_beat;

    // Classify the current R handshake and project the outstanding count.
    // A burst ends on last or on its (len+1)-th beat, whichever comes first,
    // so a missing last never leaves the count stuck. Beats arriving with
    // nothing outstanding belong to no burst and are only flagged.
    always_comb begin
        w_solicited  = (r_outstanding != '0);
        w_final_beat = (r_beat == i_len);
        o_burst_done = i_r_hs && w_solicited && (i_r_last || w_final_beat);
        o_err        = ERR_NONE;
        if (i_r_hs) begin
            if (!w_solicited)
                o_err = ERR_UNSOLICITED;
            else if (i_r_last && !w_final_beat)
                o_err = ERR_EARLY_LAST;
            else if (w_final_beat && !i_r_last)
                o_err = ERR_MISSING_LAST;
            else if (i_r_id != i_id)
                o_err = ERR_BAD_ID;
        end
        unique case ({i_ar_hs, o_burst_done})
            2'b10:   w_out_next = r_outstanding + OUT_W'(1);
            2'b01:   w_out_next = r_outstanding - OUT_W'(1);
            default: w_out_next = r_outstanding;
        endcase
        o_full_next = (w_out_next == MAX_OUT);
    end

    // Outstanding and beat counters; cleared when a new sequence starts.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_outstanding <= '0;
            r_beat        <= '0;
        end else if (i_clear) begin
            r_outstanding <= '0;
            r_beat        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (o_burst_done)
                r_beat <= '0;
            else if (i_r_hs && w_solicited)
                r_beat <= r_beat + BURST_LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/stride_read_master.sv
// Strided AXI read initiator: issues cfg_count bursts of cfg_len+1 beats
// at cfg_base + k*cfg_stride, consumes the data, folds it into an XOR
// signature and records the first protocol error seen.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. Once m_ar_valid is raised, addr/len/id hold and valid
// stays high until m_ar_ready is seen; m_r_ready is high in RUN and DRAIN.
module stride_read_master
    import stride_read_pkg::*;
#(
    parameter int ADDR_BITS            = 16,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_MAX_OUTSTANDING  = 2,
    parameter int CNT_WIDTH            = 8
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  start,
    input  logic [ADDR_BITS-1:0]                  cfg_base,
    input  logic [ADDR_BITS-1:0]                  cfg_stride,
    input  logic [CNT_WIDTH-1:0]                  cfg_count,
    input  logic [BURST_LEN_WIDTH-1:0]            cfg_len,
    input  logic [TID_WIDTH-1:0]                  cfg_id,
    output logic                                  busy,
    output logic                                  done,
    output logic [2:0]                            errorCode,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  signature,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [TID_WIDTH-1:0]                  m_ar_id,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic                                  m_r_last,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    output state_t                                o_dbg_state
);

    localparam int DATA_WIDTH = 8 << LOG_BLOCK_DATA_BYTES;

    state_t                     r_state;
    logic                       r_busy;
    logic                       r_done;
    logic [2:0]                 r_error;
    logic [DATA_WIDTH-1:0]      r_sig;
    logic                       r_ar_valid;
    logic [ADDR_BITS-1:0]       r_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] r_ar_len;
    logic [TID_WIDTH-1:0]       r_ar_id;
    logic                       r_r_ready;
    logic [ADDR_BITS-1:0]       r_stride;
    logic [CNT_WIDTH-1:0]       r_count;
    logic [CNT_WIDTH-1:0]       r_issued;
    logic [CNT_WIDTH-1:0]       r_completed;

    logic                       w_ar_hs;
    logic                       w_r_hs;
    logic                       w_clear;
    logic [CNT_WIDTH-1:0]       w_issued_next;
    logic [CNT_WIDTH-1:0]       w_completed_next;
    logic                       w_last_issue;
    logic                       w_seq_complete;
    logic                       w_burst_done;
    logic                       w_full_next;
    logic [2:0]                 w_err;

    assign w_ar_hs          = r_ar_valid && m_ar_ready;
    assign w_r_hs           = m_r_valid && r_r_ready;
    assign w_clear          = (r_state == ST_IDLE) && start;
    assign w_issued_next    = r_issued + CNT_WIDTH'(1);
    assign w_completed_next = r_completed + CNT_WIDTH'(1);
    assign w_last_issue     = w_ar_hs && (w_issued_next == r_count);
    assign w_seq_complete   = w_burst_done && (w_completed_next == r_count);

    stride_read_rtrack #(
        .BURST_LEN_WIDTH     (BURST_LEN_WIDTH),
        .TID_WIDTH           (TID_WIDTH),
        .LOG_MAX_OUTSTANDING (LOG_MAX_OUTSTANDING)
    ) u_rtrack (
        .clk          (clk),
        .resetN       (resetN),
        .i_clear      (w_clear),
        .i_ar_hs      (w_ar_hs),
        .i_r_hs       (w_r_hs),
        .i_r_last     (m_r_last),
        .i_r_id       (m_r_id),
        .i_len        (r_ar_len),
        .i_id         (r_ar_id),
        .o_burst_done (w_burst_done),
        .o_full_next  (w_full_next),
        .o_err        (w_err)
    );

    // Sequencer: latches the job, paces AR issue against the outstanding
    // limit, and retires to DONE on the handshake of the final burst end.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ar_valid <= 1'b0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_id    <= '0;
            r_r_ready  <= 1'b0;
            r_stride   <= '0;
            r_count    <= '0;
            r_issued   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_ar_addr <= cfg_base;
                        r_ar_len  <= cfg_len;
                        r_ar_id   <= cfg_id;
                        r_stride  <= cfg_stride;
                        r_count   <= cfg_count;
                        r_issued  <= '0;
                        r_busy    <= 1'b1;
                        if (cfg_count == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state    <= ST_RUN;
                            r_ar_valid <= 1'b1;
                            r_r_ready  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_ar_hs) begin
                        r_ar_addr <= r_ar_addr + r_stride;
                        r_issued  <= w_issued_next;
                        if (w_last_issue) begin
                            r_ar_valid <= 1'b0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_ar_valid <= !w_full_next;
                        end
                    end else if (!r_ar_valid) begin
                        r_ar_valid <= !w_full_next;
                    end
                end
                ST_DRAIN: begin
                    if (w_seq_complete) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_r_ready <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // Arriving from DRAIN done is already high; an empty
                    // sequence raises it here for its single cycle.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Signature, sticky first error and completed-burst count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sig       <= '0;
            r_error     <= ERR_NONE;
            r_completed <= '0;
        end else if (w_clear) begin
            r_sig       <= '0;
            r_error     <= ERR_NONE;
            r_completed <= '0;
        end else begin
            if (w_r_hs)
                r_sig <= r_sig ^ m_r_data;
            if ((r_error == ERR_NONE) && (w_err != ERR_NONE))
                r_error <= w_err;
            if (w_burst_done)
                r_completed <= w_completed_next;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign errorCode   = r_error;
    assign signature   = r_sig;
    assign m_ar_valid  = r_ar_valid;
    assign m_ar_addr   = r_ar_addr;
    assign m_ar_len    = r_ar_len;
    assign m_ar_id     = r_ar_id;
    assign m_r_ready   = r_r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stride_read_master.sv
// Directed bench for stride_read_master with a behavioural AXI read slave.
module tb_stride_read_master;
    import stride_read_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic [15:0] cfg_base, cfg_stride;
    logic [7:0]  cfg_count, cfg_len, cfg_id;
    logic        busy, done;
    logic [2:0]  errorCode;
    logic [7:0]  signature;
    logic        m_ar_valid, m_ar_ready;
    logic [7:0]  m_ar_len, m_ar_id;
    logic [15:0] m_ar_addr;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [7:0]  m_r_data, m_r_id;
    state_t      dbg_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
    } req_t;

    req_t        req_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_len, exp_id, exp_sig;
    logic [2:0]  exp_err;
    int          exp_beats;
    int          beats_at_start;
    int          ar_hs_cnt = 0;
    int          beats_rx = 0;
    int          burst_seen = 0;
    int          sl_beat = 0;
    int          inj_early_burst = -1;
    int          inj_bad_burst = -1;
    logic        r_enable;
    int          ar_base;

    stride_read_master dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .cfg_base    (cfg_base),
        .cfg_stride  (cfg_stride),
        .cfg_count   (cfg_count),
        .cfg_len     (cfg_len),
        .cfg_id      (cfg_id),
        .busy        (busy),
        .done        (done),
        .errorCode   (errorCode),
        .signature   (signature),
        .m_ar_valid  (m_ar_valid),
        .m_ar_ready  (m_ar_ready),
        .m_ar_len    (m_ar_len),
        .m_ar_addr   (m_ar_addr),
        .m_ar_id     (m_ar_id),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_last    (m_r_last),
        .m_r_data    (m_r_data),
        .m_r_id      (m_r_id),
        .o_dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory contents seen by the slave, a fixed function of address.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: samples handshakes on the falling edge, drives R just after
    // the rising edge. AR requests are scoreboarded against exp_q.
    initial begin : slave
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        m_r_data  = '0;
        m_r_id    = '0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                req_q.delete();
                sl_beat = 0;
            end else begin
                if (m_ar_valid && m_ar_ready) begin
                    ar_hs_cnt++;
                    check("ar_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("ar_addr", m_ar_addr, exp_q.pop_front());
                    check("ar_len", m_ar_len, exp_len);
                    check("ar_id", m_ar_id, exp_id);
                    req_q.push_back('{m_ar_addr, m_ar_len, m_ar_id});
                end
                if (m_r_valid && m_r_ready) begin
                    beats_rx++;
                    if (m_r_last) begin
                        void'(req_q.pop_front());
                        sl_beat = 0;
                        burst_seen++;
                    end else begin
                        sl_beat++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (resetN && r_enable && req_q.size() != 0) begin
                m_r_valid = 1'b1;
                m_r_data  = mem_byte(req_q[0].addr + 16'(sl_beat));
                m_r_last  = (sl_beat == int'(req_q[0].len)) ||
                            (burst_seen == inj_early_burst && sl_beat == 1);
                m_r_id    = req_q[0].id ^ ((burst_seen == inj_bad_burst && sl_beat == 0) ? 8'h01 : 8'h00);
            end else begin
                m_r_valid = 1'b0;
                m_r_last  = 1'b0;
            end
        end
    end

    // Queue expected AR addresses and the expected signature, then pulse start.
    task automatic pulse_start(input logic [15:0] base, input logic [15:0] stride,
                               input logic [7:0] count, input logic [7:0] len,
                               input logic [7:0] id);
        logic [15:0] a;
        exp_sig = '0;
        for (int b = 0; b < int'(count); b++) begin
            a = base + 16'(b) * stride;
            exp_q.push_back(a);
            for (int k = 0; k <= int'(len); k++)
                exp_sig ^= mem_byte(a + 16'(k));
        end
        exp_len = len;
        exp_id = id;
        exp_err = ERR_NONE;
        exp_beats = int'(count) * (int'(len) + 1);
        beats_at_start = beats_rx;
        @(posedge clk);
        #1;
        cfg_base = base;
        cfg_stride = stride;
        cfg_count = count;
        cfg_len = len;
        cfg_id = id;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Bounded wait for done, then check the completion state.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, seen, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_err"}, errorCode, exp_err);
        check({tag, "_sig"}, signature, exp_sig);
        check({tag, "_beats"}, beats_rx - beats_at_start, exp_beats);
        check({tag, "_ar_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin : main
        resetN = 1'b0;
        start = 1'b0;
        cfg_base = '0;
        cfg_stride = '0;
        cfg_count = '0;
        cfg_len = '0;
        cfg_id = '0;
        m_ar_ready = 1'b1;
        r_enable = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", errorCode, 0);
        check("rst_sig", signature, 0);
        check("rst_arvalid", m_ar_valid, 0);
        check("rst_rready", m_r_ready, 0);
        check("rst_araddr", m_ar_addr, 0);
        resetN = 1'b1;

        // Basic strided sequence, len 0
        pulse_start(16'h0100, 16'd3, 8'd4, 8'd0, 8'd5);
        @(negedge clk);
        check("t1_first_valid", m_ar_valid, 1);
        check("t1_busy", busy, 1);
        wait_done("t1");

        // Address wraparound, len 1
        pulse_start(16'hFFFE, 16'd1, 8'd3, 8'd1, 8'd2);
        wait_done("t2");
        check("t2_err_hold", errorCode, 0);

        // AR stall: ready low for 5 cycles of the first burst
        @(posedge clk);
        #1;
        m_ar_ready = 1'b0;
        ar_base = ar_hs_cnt;
        pulse_start(16'h0200, 16'h0010, 8'd2, 8'd0, 8'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_valid_stable", m_ar_valid, 1);
            check("t3_addr_stable", m_ar_addr, 16'h0200);
        end
        check("t3_no_hs", ar_hs_cnt - ar_base, 0);
        @(posedge clk);
        #1;
        m_ar_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_c6", m_ar_valid, 1);
        check("t3_addr_c6", m_ar_addr, 16'h0200);
        @(negedge clk);
        check("t3_next_addr", m_ar_addr, 16'h0210);
        wait_done("t3");

        // Outstanding limit with R withheld
        r_enable = 1'b0;
        ar_base = ar_hs_cnt;
        pulse_start(16'h0300, 16'd1, 8'd8, 8'd0, 8'd3);
        repeat (20) @(negedge clk);
        check("t4_ar_limit", ar_hs_cnt - ar_base, 4);
        check("t4_valid_low", m_ar_valid, 0);
        r_enable = 1'b1;
        @(negedge clk);
        check("t4_valid_until_last", m_ar_valid, 0);
        wait_done("t4");
        check("t4_ar_total", ar_hs_cnt - ar_base, 8);

        // Early last on burst 0, then a wrong ID on burst 1
        inj_early_burst = burst_seen;
        inj_bad_burst = burst_seen + 1;
        pulse_start(16'h0400, 16'd4, 8'd2, 8'd2, 8'd7);
        exp_sig = mem_byte(16'h0400) ^ mem_byte(16'h0401) ^
                  mem_byte(16'h0404) ^ mem_byte(16'h0405) ^ mem_byte(16'h0406);
        exp_beats = 5;
        exp_err = ERR_EARLY_LAST;
        wait_done("t5");
        repeat (3) @(negedge clk);
        check("t5_err_sticky", errorCode, ERR_EARLY_LAST);
        inj_early_burst = -1;
        inj_bad_burst = -1;

        // Empty sequence: done two cycles after start, nothing issued
        ar_base = ar_hs_cnt;
        pulse_start(16'h0800, 16'd1, 8'd0, 8'd0, 8'd1);
        check("t6_err_cleared", errorCode, 0);
        @(negedge clk);
        check("t6_done_c1", done, 0);
        check("t6_busy_c1", busy, 1);
        @(negedge clk);
        check("t6_done_c2", done, 1);
        check("t6_busy_c2", busy, 0);
        @(negedge clk);
        check("t6_done_gone", done, 0);
        check("t6_no_ar", ar_hs_cnt - ar_base, 0);

        // Reset mid-RUN
        @(posedge clk);
        #1;
        m_ar_ready = 1'b0;
        pulse_start(16'h0500, 16'd2, 8'd4, 8'd0, 8'd4);
        repeat (2) @(negedge clk);
        check("t7_valid_pre", m_ar_valid, 1);
        check("t7_busy_pre", busy, 1);
        resetN = 1'b0;
        #1;
        check("t7_valid_rst", m_ar_valid, 0);
        check("t7_busy_rst", busy, 0);
        check("t7_rready_rst", m_r_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        m_ar_ready = 1'b1;

        // Recovery after reset, len 3, zero stride
        pulse_start(16'h0010, 16'd0, 8'd2, 8'd3, 8'd6);
        wait_done("t8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
